ap_txn_profiler: RTL and testbench

Synthesizable transaction profiler that consumes the ap_ctrl_hs handshake of one non-dataflow HLS module instance (ap_start/ap_ready/ap_done/ap_continue) and turns it into per-transaction timing records. It sits directly downstream of the module-status sampling point in the myproject design: it takes the same four control signals plus the end-of-test `finish`, measures latency, initiation interval and output stall per call, and buffers the records for readout over a valid/ready port. It lets hardware runs produce the same per-call status information that simulation collects.

---
 rtl/ap_txn_pkg.sv | 25 ++
 rtl/ap_txn_fifo.sv | 54 +++++
 rtl/ap_txn_profiler.sv | 136 +++++++++++++
 tb/tb_ap_txn_profiler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ap_txn_pkg.sv
// Shared record layouts, width constants and stall-tracker state encoding for ap_txn_profiler.
package ap_txn_pkg;

  localparam int TS_W = 32;
  localparam int ID_W = 16;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] latency;
    logic [TS_W-1:0] interval;
    logic [ID_W-1:0] stall;
  } ap_txn_rec_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
  } ap_txn_pend_t;

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } ap_txn_stall_e;

endpackage

// File: rtl/ap_txn_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO succeeds when a read happens in the same cycle.
module ap_txn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // Storage is cleared on reset so the read port shows zero until the first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_ok)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ap_txn_profiler.sv
// ap_ctrl_hs transaction profiler: per-call latency/interval/stall records buffered for valid/ready readout.
// Stall tracking is built only when AP_TXN_STALL_EN is defined; otherwise the stall field reads 0.
module ap_txn_profiler #(
  parameter int TS_W       = 32,
  parameter int ID_W       = 16,
  parameter int PEND_DEPTH = 2,
  parameter int REC_DEPTH  = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  input  logic                     ap_ready,
  input  logic                     ap_done,
  input  logic                     ap_continue,
  input  logic                     finish,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [ID_W*2+TS_W*3-1:0] rec_data,
  output logic [15:0]              drop_cnt,
  output logic                     err_pend_ovf,
  output logic                     err_orphan_done,
  output logic                     flushed
);

  import ap_txn_pkg::*;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] last_acc_ts;
  logic            have_acc;
  logic [ID_W-1:0] id_cnt;
  logic            fin_latch;
  logic            acc, comp, bypass;
  logic            pend_push, pend_pop, pend_full, pend_empty;
  logic [TS_W-1:0] acc_iv;
  logic [TS_W-1:0] pend_iv_out;
  ap_txn_pend_t    pend_in, pend_out;
  ap_txn_rec_t     rec_wr;
  logic            rec_we, rec_rd, rec_full, rec_empty;
  logic [ID_W-1:0] stall_val;

  assign acc    = ap_start && ap_ready && !(fin_latch || finish);
  assign comp   = ap_done && ap_continue;
  assign acc_iv = have_acc ? ts - last_acc_ts : '0;
  assign bypass = acc && comp && pend_empty;

  assign pend_pop  = comp && !pend_empty;
  assign pend_push = acc && !bypass && (!pend_full || pend_pop);
  assign pend_in   = '{id: id_cnt, start_ts: ts};

  // The interval is computed at accept time and rides along with the pending entry.
  ap_txn_fifo #(.WIDTH($bits(ap_txn_pend_t) + TS_W), .DEPTH(PEND_DEPTH)) u_pend (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .wr_en   (pend_push),
    .wr_data ({acc_iv, pend_in}),
    .rd_en   (pend_pop),
    .rd_data ({pend_iv_out, pend_out}),
    .full    (pend_full),
    .empty   (pend_empty)
  );

  always_comb begin
    rec_wr          = '0;
    rec_wr.id       = bypass ? id_cnt : pend_out.id;
    rec_wr.start_ts = bypass ? ts : pend_out.start_ts;
    rec_wr.latency  = bypass ? '0 : ts - pend_out.start_ts;
    rec_wr.interval = bypass ? acc_iv : pend_iv_out;
    rec_wr.stall    = stall_val;
  end

  assign rec_we    = bypass || pend_pop;
  assign rec_valid = !rec_empty;
  assign rec_rd    = rec_ready && rec_valid;

  ap_txn_fifo #(.WIDTH(ID_W*2+TS_W*3), .DEPTH(REC_DEPTH)) u_rec (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .wr_en   (rec_we),
    .wr_data (rec_wr),
    .rd_en   (rec_rd),
    .rd_data (rec_data),
    .full    (rec_full),
    .empty   (rec_empty)
  );

`ifdef AP_TXN_STALL_EN
  ap_txn_stall_e   stall_st;
  logic [ID_W-1:0] stall_cnt;

  // The entry cycle counts as a stall cycle, so N low-continue cycles give stall=N.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_st  <= ST_IDLE;
      stall_cnt <= '0;
    end else if (comp) begin
      stall_st  <= ST_IDLE;
      stall_cnt <= '0;
    end else if ((ap_done && !ap_continue) || stall_st == ST_STALL) begin
      stall_st <= ST_STALL;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_val = stall_cnt;
`else
  assign stall_val = '0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts              <= '0;
      last_acc_ts     <= '0;
      have_acc        <= 1'b0;
      id_cnt          <= '0;
      fin_latch       <= 1'b0;
      drop_cnt        <= '0;
      err_pend_ovf    <= 1'b0;
      err_orphan_done <= 1'b0;
      flushed         <= 1'b0;
    end else begin
      ts        <= ts + 1'b1;
      fin_latch <= fin_latch || finish;
      if (acc) begin
        id_cnt      <= id_cnt + 1'b1;
        last_acc_ts <= ts;
        have_acc    <= 1'b1;
      end
      if (acc && pend_full && !pend_pop) err_pend_ovf <= 1'b1;
      if (comp && pend_empty && !acc) err_orphan_done <= 1'b1;
      if (rec_we && rec_full && !rec_rd && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
      if (fin_latch && pend_empty && rec_empty) flushed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Directed self-checking bench for ap_txn_profiler; expected records are hand-derived per scenario.
module tb_ap_txn_profiler;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         ap_start = 1'b0;
  logic         ap_ready = 1'b0;
  logic         ap_done = 1'b0;
  logic         ap_continue = 1'b1;
  logic         finish = 1'b0;
  logic         rec_valid;
  logic         rec_ready = 1'b0;
  logic [127:0] rec_data;
  logic [15:0]  drop_cnt;
  logic         err_pend_ovf;
  logic         err_orphan_done;
  logic         flushed;

  int n_chk  = 0;
  int n_fail = 0;
  int tnow   = 0;

`ifdef AP_TXN_STALL_EN
  localparam logic [15:0] EXP_STALL = 16'd3;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  ap_txn_profiler #(.TS_W(32), .ID_W(16), .PEND_DEPTH(2), .REC_DEPTH(8)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ap_start        (ap_start),
    .ap_ready        (ap_ready),
    .ap_done         (ap_done),
    .ap_continue     (ap_continue),
    .finish          (finish),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_data        (rec_data),
    .drop_cnt        (drop_cnt),
    .err_pend_ovf    (err_pend_ovf),
    .err_orphan_done (err_orphan_done),
    .flushed         (flushed)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [127:0] rec(input logic [15:0] id, input logic [31:0] st,
                                       input logic [31:0] lat, input logic [31:0] iv,
                                       input logic [15:0] sl);
    return {id, st, lat, iv, sl};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs set at the negedge where tnow==N are sampled by the DUT while its ts equals N.
  task automatic adv(input int n);
    while (tnow < n) begin
      @(negedge ap_clk);
      tnow++;
    end
  endtask

  task automatic reset_dut();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
    finish = 1'b0; rec_ready = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tnow = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge ap_clk);
    chk("rst_valid", rec_valid, 0);
    chk("rst_data", rec_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", err_pend_ovf, 0);
    chk("rst_orphan", err_orphan_done, 0);
    chk("rst_flushed", flushed, 0);

    // Single call
    reset_dut();
    adv(5);  ap_start = 1; ap_ready = 1;
    adv(6);  ap_start = 0; ap_ready = 0;
    adv(17); ap_done = 1;
    chk("single_not_yet", rec_valid, 0);
    adv(18); ap_done = 0;
    chk("single_valid", rec_valid, 1);
    chk("single_rec", rec_data, rec(0, 5, 12, 0, 0));
    rec_ready = 1;
    adv(19); rec_ready = 0;
    chk("single_drained", rec_valid, 0);

    // Back-to-back calls
    reset_dut();
    adv(10); ap_start = 1; ap_ready = 1;
    adv(11); ap_start = 0; ap_ready = 0;
    adv(25); ap_done = 1;
    adv(26); ap_done = 0;
    adv(30); ap_start = 1; ap_ready = 1;
    adv(31); ap_start = 0; ap_ready = 0;
    adv(45); ap_done = 1;
    adv(46); ap_done = 0;
    chk("b2b_rec0", rec_data, rec(0, 10, 15, 0, 0));
    rec_ready = 1;
    adv(47); rec_ready = 0;
    chk("b2b_rec1", rec_data, rec(1, 30, 15, 20, 0));
    adv(48);
    chk("b2b_hold_valid", rec_valid, 1);
    chk("b2b_hold_data", rec_data, rec(1, 30, 15, 20, 0));

    // Output stall
    reset_dut();
    adv(30); ap_start = 1; ap_ready = 1;
    adv(31); ap_start = 0; ap_ready = 0;
    adv(40); ap_done = 1; ap_continue = 0;
    adv(43); ap_continue = 1;
    adv(44); ap_done = 0;
    chk("stall_valid", rec_valid, 1);
    chk("stall_rec", rec_data, rec(0, 30, 13, 0, EXP_STALL));

    // Record FIFO overflow
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      adv(10 + 4*i); ap_start = 1; ap_ready = 1;
      adv(11 + 4*i); ap_start = 0; ap_ready = 0; ap_done = 1;
      adv(12 + 4*i); ap_done = 0;
    end
    adv(50);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_valid", rec_valid, 1);
    rec_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("ovf_rec", rec_data, rec(16'(k), 32'(10 + 4*k), 1, (k == 0) ? 32'd0 : 32'd4, 0));
      adv(tnow + 1);
    end
    rec_ready = 0;
    chk("ovf_empty", rec_valid, 0);

    // Pending overflow
    reset_dut();
    adv(5); ap_start = 1; ap_ready = 1;
    adv(7);
    chk("pend_ovf_before", err_pend_ovf, 0);
    adv(8); ap_start = 0; ap_ready = 0;
    chk("pend_ovf_set", err_pend_ovf, 1);
    chk("pend_ovf_no_orphan", err_orphan_done, 0);

    // Orphan done
    reset_dut();
    adv(5); ap_done = 1;
    adv(6); ap_done = 0;
    chk("orphan_set", err_orphan_done, 1);
    chk("orphan_no_rec", rec_valid, 0);
    chk("orphan_no_ovf", err_pend_ovf, 0);

    // Finish with one call pending, later accept ignored
    reset_dut();
    adv(5);  ap_start = 1; ap_ready = 1;
    adv(6);  ap_start = 0; ap_ready = 0;
    adv(8);  finish = 1;
    adv(9);  finish = 0;
    adv(10); ap_start = 1; ap_ready = 1;
    adv(11); ap_start = 0; ap_ready = 0;
    adv(15); ap_done = 1;
    adv(16); ap_done = 0;
    chk("fin_rec", rec_data, rec(0, 5, 10, 0, 0));
    chk("fin_not_flushed", flushed, 0);
    rec_ready = 1;
    adv(17); rec_ready = 0;
    chk("fin_single_rec", rec_valid, 0);
    adv(18);
    chk("fin_flushed", flushed, 1);
    adv(20); ap_done = 1;
    adv(21); ap_done = 0;
    chk("fin_orphan", err_orphan_done, 1);
    #2 ap_rst_n = 0;
    #1;
    chk("async_flushed", flushed, 0);
    chk("async_orphan", err_orphan_done, 0);

    // Asynchronous reset mid-call with a buffered record
    reset_dut();
    adv(5);  ap_start = 1; ap_ready = 1;
    adv(6);  ap_start = 0; ap_ready = 0; ap_done = 1;
    adv(7);  ap_done = 0;
    adv(8);  ap_start = 1; ap_ready = 1;
    adv(9);  ap_start = 0; ap_ready = 0;
    adv(10);
    chk("mid_valid", rec_valid, 1);
    chk("mid_rec", rec_data, rec(0, 5, 1, 0, 0));
    #2 ap_rst_n = 0;
    #1;
    chk("async_valid", rec_valid, 0);
    chk("async_data", rec_data, 0);
    chk("async_drop", drop_cnt, 0);
    @(negedge ap_clk);
    ap_rst_n = 1;
    tnow = 0;
    adv(3); ap_done = 1;
    adv(4); ap_done = 0;
    chk("post_rst_pend_gone", err_orphan_done, 1);
    chk("post_rst_no_rec", rec_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
